// File: rtl/uart_fifo_rx.sv
// UART receive front end: free-running baud tick divider, 16x-oversampled 8N1 receiver
// and a byte FIFO with a registered (non fall-through) read port.
`timescale 1ns/1ps

module uart_fifo_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int AE_THRESH  = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx_serial_data,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       almost_empty,
    output logic       empty
);

    localparam int TICK_RATE = BAUD * OVERSAMPLE;
    localparam int DIV       = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [DIV_W-1:0]  div_reg;
    logic              rx_en;
    logic [1:0]        sync_reg;
    logic              rx_line;
    state_t            state_reg, state_next;
    logic [TICK_W-1:0] tick_reg;
    logic [2:0]        bit_reg;
    logic [7:0]        shift_reg;
    logic              tick_last;
    logic              tick_mid;
    logic              sample_bit;
    logic              rx_finish;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [7:0]        dout_reg;
    logic              empty_reg, ae_reg;
    logic              do_wr, do_rd;

    // Tick divider is free-running; frames are aligned only through the start-bit search.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            div_reg <= '0;
        else if (rx_en)
            div_reg <= '0;
        else
            div_reg <= div_reg + DIV_W'(1);
    end
    assign rx_en = (div_reg == DIV_W'(DIV - 1));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            sync_reg <= 2'b11;
        else
            sync_reg <= {sync_reg[0], rx_serial_data};
    end
    assign rx_line = sync_reg[1];

    assign tick_last = (tick_reg == TICK_W'(OVERSAMPLE - 1));
    assign tick_mid  = (tick_reg == TICK_W'(OVERSAMPLE / 2 - 1));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (rx_en) begin
            case (state_reg)
                S_IDLE:  if (!rx_line) state_next = S_START;
                S_START: if (tick_mid) state_next = rx_line ? S_IDLE : S_DATA;
                S_DATA:  if (tick_last && bit_reg == 3'd7) state_next = S_STOP;
                S_STOP:  if (tick_last) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sample_bit = rx_en && (state_reg == S_DATA) && tick_last;
        rx_finish  = rx_en && (state_reg == S_STOP) && tick_last && rx_line;
    end

    // Tick counter restarts on every state change so each phase measures from its own entry.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else if (rx_en) begin
            if (state_reg != state_next || state_reg == S_IDLE || tick_last)
                tick_reg <= '0;
            else
                tick_reg <= tick_reg + TICK_W'(1);
            if (state_reg == S_START)
                bit_reg <= '0;
            else if (sample_bit)
                bit_reg <= bit_reg + 3'd1;
            if (sample_bit)
                shift_reg <= {rx_line, shift_reg[7:1]};
        end
    end

    assign do_wr = rx_finish && (count_reg != CNT_W'(FIFO_DEPTH));
    assign do_rd = rd_en && (count_reg != '0);

    always_ff @(posedge clk_in) begin
        if (do_wr)
            mem[wr_ptr_reg] <= shift_reg;
    end

    always_comb begin
        count_next = count_reg;
        if (do_wr && !do_rd)
            count_next = count_reg + CNT_W'(1);
        else if (!do_wr && do_rd)
            count_next = count_reg - CNT_W'(1);
    end

    // Flags are registered from the post-update count so they track the same edge as the data.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
            empty_reg  <= 1'b1;
            ae_reg     <= 1'b1;
        end else begin
            if (do_wr)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                dout_reg   <= mem[rd_ptr_reg];
            end
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            ae_reg    <= (count_next <= CNT_W'(AE_THRESH));
        end
    end

    assign dout         = dout_reg;
    assign empty        = empty_reg;
    assign almost_empty = ae_reg;

endmodule

// File: tb/tb_uart_fifo_rx.sv
// Scoreboard bench for uart_fifo_rx: frames are driven on the serial pin, expected bytes
// queued at send time, and a monitor compares dout after every accepted read.
`timescale 1ns/1ps

module tb_uart_fifo_rx;

    // Bit rate picked so the tick divider is exact (4 clk per tick, 64 clk per bit).
    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD_TB = 781_250;
    localparam int BIT_NS  = 1280;
    localparam int TICK_NS = BIT_NS / 16;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       rx_serial_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       almost_empty;
    logic       empty;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic       pend = 1'b0;

    always #10 clk_in = ~clk_in;

    uart_fifo_rx #(
        .CLK_FREQ(CLK_HZ),
        .BAUD(BAUD_TB),
        .OVERSAMPLE(16),
        .FIFO_DEPTH(16),
        .AE_THRESH(1)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .rx_serial_data(rx_serial_data),
        .rd_en(rd_en),
        .dout(dout),
        .almost_empty(almost_empty),
        .empty(empty)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h want 0x%02h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%02h", name, act);
        end
    endtask

    // Monitor: a read accepted before one rising edge shows its byte on dout after it.
    always @(negedge clk_in) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read_data: got 0x%02h want nothing queued", dout);
            end else begin
                check("read_data", dout, exp_q.pop_front());
            end
        end
        pend = rst && rd_en && !empty;
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit expect_store);
        if (expect_store)
            exp_q.push_back(b);
        @(negedge clk_in);
        rx_serial_data = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_serial_data = b[i];
            #(BIT_NS);
        end
        if (stop_ok) begin
            rx_serial_data = 1'b1;
            #(BIT_NS);
        end else begin
            // Low only past the stop sample point so the line is idle again before a restart check.
            rx_serial_data = 1'b0;
            #(BIT_NS * 3 / 4);
            rx_serial_data = 1'b1;
            #(BIT_NS * 2);
        end
        $display("sent 0x%02h stop=%0d", b, stop_ok);
    endtask

    task automatic read_byte();
        @(posedge clk_in);
        #1 rd_en = 1'b1;
        @(posedge clk_in);
        #1 rd_en = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        // Reset state
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_dout", dout, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_ae", almost_empty, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk_in);

        // 1: single byte
        send_frame(8'h55, 1'b1, 1'b1);
        check("t1_empty", empty, 1'b0);
        check("t1_ae", almost_empty, 1'b1);
        read_byte();
        check("t1_empty_rd", empty, 1'b1);
        check("t1_ae_rd", almost_empty, 1'b1);

        // 2: back-to-back frames, almost_empty threshold, read of empty FIFO
        send_frame(8'hA3, 1'b1, 1'b1);
        check("t2_empty_c1", empty, 1'b0);
        check("t2_ae_c1", almost_empty, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b1);
        check("t2_ae_c2", almost_empty, 1'b0);
        read_byte();
        check("t2_ae_rd1", almost_empty, 1'b1);
        check("t2_empty_rd1", empty, 1'b0);
        read_byte();
        check("t2_empty_rd2", empty, 1'b1);
        read_byte();
        check("t2_dout_hold", dout, 8'h0F);

        // 3: short low glitch rejected at the mid-start check
        @(negedge clk_in);
        rx_serial_data = 1'b0;
        #(TICK_NS * 3);
        rx_serial_data = 1'b1;
        #(BIT_NS * 12);
        check("t3_empty", empty, 1'b1);

        // 4: framing error drops the byte, next frame still received
        send_frame(8'h7E, 1'b0, 1'b0);
        check("t4_empty_bad", empty, 1'b1);
        send_frame(8'h42, 1'b1, 1'b1);
        check("t4_empty_ok", empty, 1'b0);
        read_byte();
        check("t4_empty_rd", empty, 1'b1);

        // 5: overflow, 17th byte lost
        for (int i = 0; i < 17; i++)
            send_frame(8'(i), 1'b1, i < 16);
        check("t5_empty_full", empty, 1'b0);
        check("t5_ae_full", almost_empty, 1'b0);
        for (int i = 0; i < 16; i++)
            read_byte();
        check("t5_empty_drained", empty, 1'b1);
        read_byte();
        check("t5_dout_hold", dout, 8'h0F);

        // 6: reset in the middle of data bit 3
        @(negedge clk_in);
        rx_serial_data = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx_serial_data = 1'(8'hC9 >> i);
            #(BIT_NS);
        end
        rx_serial_data = 1'b1;
        #(BIT_NS / 2);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        check("t6_rst_dout", dout, 8'h00);
        check("t6_rst_empty", empty, 1'b1);
        check("t6_rst_ae", almost_empty, 1'b1);
        rst = 1'b1;
        #(BIT_NS * 12);
        check("t6_empty_idle", empty, 1'b1);
        send_frame(8'hC9, 1'b1, 1'b1);
        check("t6_empty", empty, 1'b0);
        read_byte();
        check("t6_empty_rd", empty, 1'b1);

        repeat (2) @(negedge clk_in);
        check("queue_left", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
